instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
- Word-addressed, read-only instruction store for the pipelined MIPS fetch stage; one 64-bit instruction per address.
- Synchronous read: the address presented before a rising edge is returned on `ins` after that edge.
- Contents are a fixed built-in program defined by a deterministic formula.
- An optional programming port allows the contents to be overwritten.

Parameters:
- ADDR_W, 16, address width in bits.
- INSTR_W, 64, instruction width in bits.
- DEPTH, 32, number of implemented words; legal addresses are 0..DEPTH-1, DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_W  word index of the instruction to fetch.
- ins  output  INSTR_W  registered instruction word.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - rst_n low forces ins to 64'h0 (NOP) immediately, independent of clk.
  - ins stays 0 while rst_n is low.
  - The first read occurs on the first rising edge after rst_n deasserts.
  - Reset never alters array contents.
- Read:
  - On each rising edge with rst_n high, ins <= mem[address].
  - Latency is exactly 1 cycle; there is no enable or handshake, so a read happens every cycle.
  - ins holds its value between edges; address changes between edges have no effect until the next edge.
- Out of range: address >= DEPTH returns 64'h0 (NOP) on the next edge; there is no wrap-around or aliasing.
- Built-in contents, for i in 0..DEPTH-1: mem[i] = {16'hC0DE, i[15:0], 16'h0000, ~i[15:0]}.
  - Example: mem[0] = 64'hC0DE_0000_0000_FFFF.
  - Example: mem[1] = 64'hC0DE_0001_0000_FFFE.
- Initialisation: contents are established at elaboration/initialisation, with no runtime load sequence.
- Address is treated as unsigned; no byte-offset shifting (address is a word index, not a byte address).

Optional Feature:
- Macro: INSTR_MEM_WRITE_PORT_EN.
- Defined: adds three ports:
  - wr_en  input  1
  - wr_addr  input  ADDR_W
  - wr_data  input  INSTR_W
- Write rules when defined:
  - On a rising edge with rst_n high and wr_en high, mem[wr_addr] <= wr_data.
  - Writes to wr_addr >= DEPTH are ignored.
  - Read-during-write to the same address is read-first: ins gets the old word, and the new word is visible from the next edge.
  - Writes are blocked while rst_n is low.
- Not defined: no write ports; the array is a pure ROM holding the built-in contents.

Decomposition:
- Package instr_mem_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - NOP_INSTR = 64'h0.
  - Signature constant 16'hC0DE.
  - A function default_word(i) returning the built-in content formula; used by both RTL initialisation and the bench's reference model.
- No sub-module is required; the array and output register live in instruction_memory.

Test Plan:
- Reset state: rst_n=0, address=0, toggle clk -> ins=64'h0 throughout. Release rst_n -> after the first edge ins=64'hC0DE_0000_0000_FFFF.
- Address change: with address=0 held, switch address to 1 between edges -> ins unchanged until the next edge, then 64'hC0DE_0001_0000_FFFE. Switch back to 0 -> 64'hC0DE_0000_0000_FFFF one edge later.
- Sequence: address=3 then address=20 -> 64'hC0DE_0003_0000_FFFC, then 64'hC0DE_0014_0000_FFEB, each with exactly 1-cycle latency.
- Boundary:
  - address=31 -> 64'hC0DE_001F_0000_FFE0.
  - address=32 -> 64'h0.
  - address=16'hFFFF -> 64'h0.
- Reset mid-operation: assert rst_n low between edges while ins is nonzero -> ins=0 immediately. Release with address=1 -> ins=64'hC0DE_0001_0000_FFFE after the next edge (contents intact).
- With INSTR_MEM_WRITE_PORT_EN:
  - Write 64'hDEAD_BEEF_0123_4567 to address 5 while reading address 5 -> that edge returns 64'hC0DE_0005_0000_FFFA, and the next edge returns 64'hDEAD_BEEF_0123_4567.
  - A write to address 40 is ignored; a subsequent read of address 40 returns 64'h0.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared constants and the built-in program formula for the instruction store.
// default_word() is the single source of the ROM image for design and bench alike.
package instr_mem_pkg;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_INSTR_W = 64;
  localparam int DEFAULT_DEPTH   = 32;

  typedef logic [63:0] instr_t;

  localparam instr_t      NOP_INSTR = 64'h0;
  localparam logic [15:0] SIGNATURE = 16'hC0DE;

  // Built-in word i: signature, index, zero half-word, inverted index.
  function automatic instr_t default_word(input logic [15:0] idx);
    return {SIGNATURE, idx, 16'h0000, ~idx};
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a registered, one-cycle-latency read port.
// Define INSTR_MEM_WRITE_PORT_EN to add a read-first programming port (wr_en/wr_addr/wr_data).
module instruction_memory
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSTR_W = DEFAULT_INSTR_W,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  address,
`ifdef INSTR_MEM_WRITE_PORT_EN
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
`endif
  output logic [INSTR_W-1:0] ins
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
`ifdef INSTR_MEM_WRITE_PORT_EN
    logic [INSTR_W-1:0] word = INSTR_W'(default_word(16'(g)));

    // NOTE: storage deliberately has no reset; only the output register is
    // cleared, so a reset pulse can never disturb a programmed image.
    always_ff @(posedge clk) begin
      if (rst_n && wr_en && (wr_addr == ADDR_W'(g)))
        word <= wr_data;
    end
`else
    localparam logic [INSTR_W-1:0] word = INSTR_W'(default_word(16'(g)));
`endif
    assign mem[g] = word;
  end

  // Extra MSB keeps the compare exact even when DEPTH == 2**ADDR_W.
  assign in_range = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
  assign idx      = address[IDX_W-1:0];

  // NOTE: non-blocking assignment here is what makes a same-edge write
  // read-first: the read samples the word before the write updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ins <= NOP;
    else if (in_range)
      ins <= mem[idx];
    else
      ins <= NOP;
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed vectors with literal
// expectations plus a per-cycle comparison against an array-based reference model.
module tb_instruction_memory;
  import instr_mem_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 64;
  localparam int DEPTH   = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [ADDR_W-1:0]  address;
  logic [INSTR_W-1:0] ins;
`ifdef INSTR_MEM_WRITE_PORT_EN
  logic               wr_en   = 1'b0;
  logic [ADDR_W-1:0]  wr_addr = '0;
  logic [INSTR_W-1:0] wr_data = '0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  instruction_memory #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
`ifdef INSTR_MEM_WRITE_PORT_EN
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .ins     (ins)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [INSTR_W-1:0] act,
                       input logic [INSTR_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain array of words and the value ins must hold.
  logic [INSTR_W-1:0] model_mem [DEPTH];
  logic [INSTR_W-1:0] exp_ins = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = default_word(16'(i));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ins = '0;
    end else begin
      exp_ins = (int'(address) < DEPTH) ? model_mem[address[4:0]] : '0;
`ifdef INSTR_MEM_WRITE_PORT_EN
      if (wr_en && int'(wr_addr) < DEPTH) model_mem[wr_addr[4:0]] = wr_data;
`endif
    end
  end

  always @(negedge clk) check("model_cycle", ins, exp_ins);

  task automatic step(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] exp,
                      input string name);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1 check(name, ins, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    address = '0;

    check("pkg_word0", default_word(16'd0), 64'hC0DE_0000_0000_FFFF);
    check("pkg_word1", default_word(16'd1), 64'hC0DE_0001_0000_FFFE);

    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", ins, 64'h0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_read", ins, 64'hC0DE_0000_0000_FFFF);

    // Address change between edges must not disturb ins until the next edge.
    @(negedge clk);
    address = 16'd1;
    #1 check("hold_between_edges", ins, 64'hC0DE_0000_0000_FFFF);
    @(posedge clk);
    #1 check("addr1", ins, 64'hC0DE_0001_0000_FFFE);
    step(16'd0,     64'hC0DE_0000_0000_FFFF, "addr0_again");
    step(16'd3,     64'hC0DE_0003_0000_FFFC, "addr3");
    step(16'd20,    64'hC0DE_0014_0000_FFEB, "addr20");
    step(16'd31,    64'hC0DE_001F_0000_FFE0, "addr31_last");
    step(16'd32,    64'h0,                   "addr32_oob");
    step(16'hFFFF,  64'h0,                   "addrFFFF_oob");
    step(16'd31,    64'hC0DE_001F_0000_FFE0, "addr31_again");

    // Asynchronous reset mid-operation, then recovery with contents intact.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", ins, 64'h0);
    address = 16'd1;
    @(posedge clk);
    #1 check("reset_mid_hold", ins, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_reset_addr1", ins, 64'hC0DE_0001_0000_FFFE);

    // Sweep across and past the array; the model compare covers each cycle.
    for (int a = 0; a < DEPTH + 4; a++) begin
      @(negedge clk);
      address = ADDR_W'(a);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      address = ADDR_W'($urandom_range(0, 40));
    end

`ifdef INSTR_MEM_WRITE_PORT_EN
    // Read-first on a same-address write.
    @(negedge clk);
    address = 16'd5;
    wr_en   = 1'b1;
    wr_addr = 16'd5;
    wr_data = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk);
    #1 check("rdw_old_word", ins, 64'hC0DE_0005_0000_FFFA);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1 check("rdw_new_word", ins, 64'hDEAD_BEEF_0123_4567);

    // Out-of-range write is dropped and does not alias onto word 8.
    @(negedge clk);
    address = 16'd40;
    wr_en   = 1'b1;
    wr_addr = 16'd40;
    wr_data = 64'h1111_2222_3333_4444;
    @(posedge clk);
    #1 check("oob_write_read", ins, 64'h0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1 check("oob_read_after", ins, 64'h0);
    step(16'd8, 64'hC0DE_0008_0000_FFF7, "no_alias_addr8");

    // Writes are blocked while reset is asserted.
    @(negedge clk);
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 16'd6;
    wr_data = 64'h5555_6666_7777_8888;
    address = 16'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("write_blocked_in_reset", ins, 64'hC0DE_0006_0000_FFF9);
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
